store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port st_valid  in  1  MEM-stage store request.
REQ-005 SHALL have port st_pc  in  32  PC of the store instruction.
REQ-006 SHALL have port st_addr  in  32  byte address of the store.
REQ-007 SHALL have port st_data  in  32  word to store.
REQ-008 SHALL have port st_ready  out  1  buffer can accept a store this cycle.
REQ-009 SHALL have port ld_addr  in  32  byte address of the current MEM-stage load.
REQ-010 SHALL have port ld_hit  out  1  a buffered store matches ld_addr.
REQ-011 SHALL have port ld_data  out  32  forwarded word when ld_hit.
REQ-012 SHALL have port ld_conflict  out  1  load must stall, because forwarding is absent.
REQ-013 SHALL have port drain_en  in  1  permission to write the head entry to data memory.
REQ-014 SHALL have ports dm_we/dm_pc/dm_addr/dm_wd  out  1/32/32/32  data-memory write port.
REQ-015 SHALL have ports count  out  5  occupied entries, and empty  out  1.

Function
REQ-016 SHALL operate as an in-order FIFO of {pc, addr, data} entries with head/tail pointers wrapping modulo DEPTH.
REQ-017 SHALL drive st_ready = (count != DEPTH); a store is enqueued at a rising edge when st_valid && st_ready.
REQ-018 SHALL NOT enqueue while full, even when the head drains in the same cycle.
REQ-019 SHALL drive dm_we = !empty && drain_en combinationally; dm_pc/dm_addr/dm_wd SHALL show the head entry, and SHALL be 0 when empty.
REQ-020 SHALL dequeue the head at the rising edge where dm_we=1; the minimum latency from enqueue to dm_we is one cycle.
REQ-021 SHALL support enqueue and dequeue in the same edge, with count unchanged and both pointers advancing.
REQ-022 SHALL compare word addresses only (addr[31:2]); byte offset bits SHALL be ignored.
REQ-023 SHALL compute the load match combinationally over valid entries only, selecting the youngest match.
REQ-024 SHALL NOT include the store being enqueued in the same cycle in the load match.
REQ-025 SHALL treat a match against the head entry being drained that cycle as still valid.
REQ-026 SHALL keep count in range 0..DEPTH and empty = (count == 0) at all times.

Reset
REQ-027 SHALL, on reset assertion, immediately clear the pointers, count and all entry valid bits, regardless of clk.
REQ-028 SHALL discard pending stores when reset is asserted mid-operation, with no dm_we issued for them.
REQ-029 SHALL hold these values while reset is asserted: st_ready=1, empty=1, count=0, dm_we=0, ld_hit=0, ld_conflict=0, ld_data=0.

Configuration
REQ-030 SHALL compile load forwarding in when STORE_BUF_FWD_EN is defined.
REQ-031 SHALL, with STORE_BUF_FWD_EN defined: ld_hit = match, ld_data = youngest matching data, ld_conflict = 0.
REQ-032 SHALL, without STORE_BUF_FWD_EN: ld_hit = 0, ld_data = 0, ld_conflict = match, and contain no data-select logic.

Structure
REQ-033 SHALL take the DEPTH default, the entry field widths and the word-address slice constants from shared package store_buffer_pkg.
REQ-034 SHALL implement youngest-match selection in sub-module sb_match, which takes the valid/address vectors plus tail and returns a hit flag and an entry index.

Verification
REQ-035 SHALL cover: with reset released and drain_en=0, enqueue 4 stores to 0x0, 0x4, 0x8, 0xC -> count=4, st_ready=0; a fifth st_valid is ignored.
REQ-036 SHALL cover: with drain_en=1 from the full state -> dm_we for four cycles, dm_addr 0x0, 0x4, 0x8, 0xC in order, then empty=1 and dm_we=0.
REQ-037 SHALL cover: stores 0x11111111 then 0x22222222 to 0x10, then ld_addr=0x12 -> ld_hit=1, ld_data=0x22222222 (FWD_EN); without FWD_EN, ld_conflict=1.
REQ-038 SHALL cover: count=2 with simultaneous enqueue and drain -> count stays 2 and pointers wrap correctly across DEPTH.
REQ-039 SHALL cover: reset pulse mid-cycle with count=3 -> count=0 and empty=1 immediately, and no later dm_we for the old entries.
REQ-040 SHALL cover: ld_addr matching only a store enqueued in the same cycle -> ld_hit=0 that cycle and ld_hit=1 the next cycle.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared constants and types for the store buffer and its match sub-block:
// default depth, entry field widths, word-address slice and the entry record.
// -----------------------------------------------------------------------------
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int PC_W             = 32;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int COUNT_W          = 5;

  // Loads and stores are matched on word granularity; byte offset is ignored.
  localparam int WADDR_MSB = 31;
  localparam int WADDR_LSB = 2;
  localparam int WADDR_W   = WADDR_MSB - WADDR_LSB + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a[WADDR_MSB:WADDR_LSB];
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Youngest-match search over the store buffer entries.
//   valid_i    : per-entry valid bits
//   waddr_i    : per-entry word addresses, entry k at [k*WADDR_W +: WADDR_W]
//   ld_waddr_i : word address of the load being looked up
//   tail_i     : tail pointer (next slot to write); tail-1 is the youngest entry
//   hit_o      : at least one valid entry matches
//   idx_o      : index of the youngest matching entry (0 when no hit)
// -----------------------------------------------------------------------------
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH*WADDR_W-1:0] waddr_i,
  input  logic [WADDR_W-1:0]       ld_waddr_i,
  input  logic [PTR_W-1:0]         tail_i,
  output logic                     hit_o,
  output logic [PTR_W-1:0]         idx_o
);

  logic [DEPTH-1:0] eq;
  logic [PTR_W-1:0] pos;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_eq
    assign eq[gi] = valid_i[gi] && (waddr_i[gi*WADDR_W +: WADDR_W] == ld_waddr_i);
  end

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); later
  // hits overwrite earlier ones so the youngest match wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    pos   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      pos = tail_i - PTR_W'(k);
      if (eq[pos]) begin
        hit_o = 1'b1;
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// In-order FIFO of {pc, addr, data} stores between the MEM stage and data
// memory, with a load-address lookup over the buffered stores.
//
// Ports
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   st_valid/pc/addr/data : MEM-stage store request; st_ready = not full
//   ld_addr               : MEM-stage load address to look up
//   ld_hit/ld_data        : forwarded youngest matching store (forwarding build)
//   ld_conflict           : load matches a buffered store (non-forwarding build)
//   drain_en              : permission to write the head entry to memory
//   dm_we/pc/addr/wd      : data-memory write port, shows the head entry
//   count, empty          : occupancy
//
// Configuration macro
//   STORE_BUF_FWD_EN : when defined, matching loads are forwarded the data.
//                      Otherwise a match only raises ld_conflict.
// -----------------------------------------------------------------------------
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st_valid,
  input  logic [PC_W-1:0]    st_pc,
  input  logic [ADDR_W-1:0]  st_addr,
  input  logic [DATA_W-1:0]  st_data,
  output logic               st_ready,
  input  logic [ADDR_W-1:0]  ld_addr,
  output logic               ld_hit,
  output logic [DATA_W-1:0]  ld_data,
  output logic               ld_conflict,
  input  logic               drain_en,
  output logic               dm_we,
  output logic [PC_W-1:0]    dm_pc,
  output logic [ADDR_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  dm_wd,
  output logic [COUNT_W-1:0] count,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t          entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic      enq;
  logic      deq;
  sb_entry_t head_entry;

  logic [DEPTH*WADDR_W-1:0] waddr_vec;
  logic                     match_hit;
  logic [PTR_W-1:0]         match_idx;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  // Fullness is judged on the current count, so a full buffer refuses a store
  // even in a cycle where the head drains.
  assign st_ready = (count_q != COUNT_W'(DEPTH));

  assign enq   = st_valid && st_ready;
  assign dm_we = !empty && drain_en;
  assign deq   = dm_we;

  assign head_entry = entry_q[head_q];
  assign dm_pc      = empty ? '0 : head_entry.pc;
  assign dm_addr    = empty ? '0 : head_entry.addr;
  assign dm_wd      = empty ? '0 : head_entry.data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q + COUNT_W'(enq) - COUNT_W'(deq);
    if (deq) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    if (enq) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset: an entry is only observed while valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_q[tail_q] <= '{pc: st_pc, addr: st_addr, data: st_data};
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_waddr
    assign waddr_vec[gi*WADDR_W +: WADDR_W] = word_addr(entry_q[gi].addr);
  end

  // The lookup sees registered valid bits only: a store being enqueued this
  // cycle is not yet visible, and the head being drained still is.
  sb_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .valid_i    (valid_q),
    .waddr_i    (waddr_vec),
    .ld_waddr_i (word_addr(ld_addr)),
    .tail_i     (tail_q),
    .hit_o      (match_hit),
    .idx_o      (match_idx)
  );

`ifdef STORE_BUF_FWD_EN
  assign ld_hit      = match_hit;
  assign ld_data     = match_hit ? entry_q[match_idx].data : '0;
  assign ld_conflict = 1'b0;
`else
  logic unused_match_idx;
  assign unused_match_idx = ^match_idx;
  assign ld_hit      = 1'b0;
  assign ld_data     = '0;
  assign ld_conflict = match_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed scenarios followed by random traffic, checked every cycle against a
// queue-based reference model of the store buffer.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_pc, st_addr, st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        drain_en;
  logic        dm_we;
  logic [31:0] dm_pc, dm_addr, dm_wd;
  logic [4:0]  count;
  logic        empty;

  int vectors     = 0;
  int miscompares = 0;
  int pc_ctr      = 32'h100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_pc       (st_pc),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_data     (ld_data),
    .ld_conflict (ld_conflict),
    .drain_en    (drain_en),
    .dm_we       (dm_we),
    .dm_pc       (dm_pc),
    .dm_addr     (dm_addr),
    .dm_wd       (dm_wd),
    .count       (count),
    .empty       (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the model queue (front = oldest entry).
  task automatic check_outputs(input string step);
    logic        exp_hit;
    logic [31:0] exp_data;
    bit          has;
    exp_hit  = 1'b0;
    exp_data = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!exp_hit && (mq[i].addr >> 2) == (ld_addr >> 2)) begin
        exp_hit  = 1'b1;
        exp_data = mq[i].data;
      end
    end
    has = (mq.size() != 0);
    chk({step, ":count"},    32'(count),    32'(mq.size()));
    chk({step, ":empty"},    32'(empty),    32'(!has));
    chk({step, ":st_ready"}, 32'(st_ready), 32'(mq.size() != D));
    chk({step, ":dm_we"},    32'(dm_we),    32'(has && drain_en));
    chk({step, ":dm_addr"},  dm_addr,       has ? mq[0].addr : 32'h0);
    chk({step, ":dm_pc"},    dm_pc,         has ? mq[0].pc   : 32'h0);
    chk({step, ":dm_wd"},    dm_wd,         has ? mq[0].data : 32'h0);
`ifdef STORE_BUF_FWD_EN
    chk({step, ":ld_hit"},      32'(ld_hit),      32'(exp_hit));
    chk({step, ":ld_data"},     ld_data,          exp_data);
    chk({step, ":ld_conflict"}, 32'(ld_conflict), 32'h0);
`else
    chk({step, ":ld_hit"},      32'(ld_hit),      32'h0);
    chk({step, ":ld_data"},     ld_data,          32'h0);
    chk({step, ":ld_conflict"}, 32'(ld_conflict), 32'(exp_hit));
`endif
  endtask

  // One clock cycle: drive inputs just after an edge, check mid-cycle, then
  // advance the model with the same enqueue/dequeue rules and take the edge.
  task automatic cycle(input string step, input logic v, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] la, input logic dr);
    bit do_enq, do_deq;
    st_valid = v;
    st_pc    = pc_ctr;
    st_addr  = addr;
    st_data  = data;
    ld_addr  = la;
    drain_en = dr;
    #3;
    check_outputs(step);
    do_enq = v && (mq.size() != D);
    do_deq = dr && (mq.size() != 0);
    if (do_deq) void'(mq.pop_front());
    if (do_enq) mq.push_back('{pc: pc_ctr, addr: addr, data: data});
    $display("[%0t] %s v=%0b a=%h d=%h ld=%h dr=%0b -> cnt=%0d we=%0b dm_a=%h hit=%0b conf=%0b",
             $time, step, v, addr, data, la, dr, count, dm_we, dm_addr, ld_hit, ld_conflict);
    pc_ctr += 4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_pc    = '0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
    drain_en = 1'b1;
    #2;
    check_outputs("reset_hold");
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full with drain disabled; a fifth store is refused.
    cycle("fill0", 1, 32'h0, 32'hA0, 32'h100, 0);
    cycle("fill1", 1, 32'h4, 32'hA1, 32'h100, 0);
    cycle("fill2", 1, 32'h8, 32'hA2, 32'h100, 0);
    cycle("fill3", 1, 32'hC, 32'hA3, 32'h100, 0);
    cycle("full_refuse", 1, 32'h10, 32'hEE, 32'h8, 0);
    cycle("full_hold", 0, 32'h0, 32'h0, 32'h10, 0);

    // Drain all four in order; then empty with drain still requested.
    for (int i = 0; i < 4; i++) cycle($sformatf("drain%0d", i), 0, 32'h0, 32'h0, 32'h4, 1);
    cycle("drained", 0, 32'h0, 32'h0, 32'h0, 1);

    // Two stores to the same word; load to a different byte of that word.
    cycle("st_a", 1, 32'h10, 32'h11111111, 32'h10, 0);
    cycle("st_b", 1, 32'h10, 32'h22222222, 32'h10, 0);
    cycle("ld_fwd", 0, 32'h0, 32'h0, 32'h12, 0);

    // Load matching only the store being enqueued this very cycle.
    cycle("same_cyc", 1, 32'h40, 32'h33333333, 32'h41, 0);
    cycle("next_cyc", 0, 32'h0, 32'h0, 32'h43, 0);

    // Drop to two entries, then simultaneous enqueue and drain across the wrap.
    cycle("to_two", 0, 32'h0, 32'h0, 32'h10, 1);
    for (int i = 0; i < 6; i++)
      cycle($sformatf("enq_deq%0d", i), 1, 32'h80 + 32'(i * 4), 32'hC0 + 32'(i), 32'h80, 1);

    // Grow to three entries, then reset in the middle of a cycle.
    cycle("to_three", 1, 32'h200, 32'hD0, 32'h0, 0);
    reset    = 1'b1;
    st_valid = 1'b0;
    drain_en = 1'b1;
    #1;
    mq.delete();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_edge");
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle($sformatf("post_rst%0d", i), 0, 32'h0, 32'h0, 32'h200, 1);

    // Random traffic over a small address pool so loads often hit.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, la;
      a  = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      la = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom, la,
            1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
